// File: rtl/exc_ctrl_if.sv
// Bundle between the MEM stage / cp0 and the exception sequencer.
// The slave modport is the sequencer's view; master is the pipeline/cp0 side.
interface exc_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_in_delayslot;
  logic        exc_if_adel;
  logic        exc_ri;
  logic        exc_ov;
  logic        exc_syscall;
  logic        exc_break;
  logic        exc_adel;
  logic        exc_ades;
  logic        exc_eret;
  logic [31:0] mem_bad_addr;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        bus_busy;
  logic [31:0] excepttype_o;
  logic [31:0] current_inst_addr_o;
  logic        is_in_delayslot_o;
  logic [31:0] bad_addr_o;
  logic        stall_req_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        new_pc_valid_o;

  modport slave (
    input  mem_valid, mem_pc, mem_in_delayslot,
    input  exc_if_adel, exc_ri, exc_ov, exc_syscall, exc_break,
    input  exc_adel, exc_ades, exc_eret, mem_bad_addr,
    input  status_i, cause_i, epc_i, bus_busy,
    output excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
    output stall_req_o, flush_o, new_pc_o, new_pc_valid_o
  );

  modport master (
    output mem_valid, mem_pc, mem_in_delayslot,
    output exc_if_adel, exc_ri, exc_ov, exc_syscall, exc_break,
    output exc_adel, exc_ades, exc_eret, mem_bad_addr,
    output status_i, cause_i, epc_i, bus_busy,
    input  excepttype_o, current_inst_addr_o, is_in_delayslot_o, bad_addr_o,
    input  stall_req_o, flush_o, new_pc_o, new_pc_valid_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises MEM-stage exceptions, waits for the
// data bus to drain, then commits one record to cp0, flushes and redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  localparam int unsigned CODE_W = 5;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;
  localparam logic [1:0] S_FLUSH  = 2'd3;

  localparam logic [CODE_W-1:0] C_INT  = 5'h01;
  localparam logic [CODE_W-1:0] C_ADEL = 5'h04;
  localparam logic [CODE_W-1:0] C_ADES = 5'h05;
  localparam logic [CODE_W-1:0] C_SYS  = 5'h08;
  localparam logic [CODE_W-1:0] C_BRK  = 5'h09;
  localparam logic [CODE_W-1:0] C_RI   = 5'h0a;
  localparam logic [CODE_W-1:0] C_OV   = 5'h0c;
  localparam logic [CODE_W-1:0] C_ERET = 5'h0e;

  // FLUSH lasts FLUSH_CYCLES-1 cycles; the counter runs down to zero inclusive.
  localparam logic [CNT_W-1:0] CNT_INIT =
    (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : '0;
  localparam logic HAS_FLUSH = (FLUSH_CYCLES > 1);

  logic [1:0]        state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CODE_W-1:0] code_q;
  logic [31:0]       pc_q;
  logic              ds_q;
  logic [31:0]       bad_q;

  logic              int_pend;
  logic              any_exc;
  logic              hit;
  logic [CODE_W-1:0] det_code;
  logic [31:0]       det_bad;

  logic              unused_cp0_bits;
  assign unused_cp0_bits = ^{bus.status_i[31:16], bus.status_i[7:2],
                             bus.cause_i[31:16], bus.cause_i[7:0]};

  // Priority encoder over pending interrupt and MEM-stage flags.
  always_comb begin
    int_pend = bus.status_i[0] & ~bus.status_i[1] &
               (|(bus.cause_i[15:8] & bus.status_i[15:8]));
    det_code = '0;
    det_bad  = '0;
    any_exc  = 1'b1;
    if (int_pend) begin
      det_code = C_INT;
    end else if (bus.exc_if_adel) begin
      det_code = C_ADEL;
      det_bad  = bus.mem_pc;
    end else if (bus.exc_ri) begin
      det_code = C_RI;
    end else if (bus.exc_ov) begin
      det_code = C_OV;
    end else if (bus.exc_syscall) begin
      det_code = C_SYS;
    end else if (bus.exc_break) begin
      det_code = C_BRK;
    end else if (bus.exc_adel) begin
      det_code = C_ADEL;
      det_bad  = bus.mem_bad_addr;
    end else if (bus.exc_ades) begin
      det_code = C_ADES;
      det_bad  = bus.mem_bad_addr;
    end else if (bus.exc_eret) begin
      det_code = C_ERET;
    end else begin
      any_exc = 1'b0;
    end
  end

  // Gated by rst so the combinational stall stays low while reset is asserted.
  assign hit = rst & (state == S_IDLE) & bus.mem_valid & any_exc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_nxt          = state;
    bus.stall_req_o    = 1'b0;
    bus.flush_o        = 1'b0;
    bus.new_pc_valid_o = 1'b0;
    bus.new_pc_o       = '0;
    bus.excepttype_o   = '0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          bus.stall_req_o = 1'b1;
          state_nxt       = bus.bus_busy ? S_DRAIN : S_COMMIT;
        end
      end
      S_DRAIN: begin
        bus.stall_req_o = 1'b1;
        if (!bus.bus_busy) begin
          state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        bus.excepttype_o   = 32'(code_q);
        bus.flush_o        = 1'b1;
        bus.new_pc_valid_o = 1'b1;
        bus.new_pc_o       = (code_q == C_ERET) ? bus.epc_i : EXC_VECTOR;
        state_nxt          = HAS_FLUSH ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        bus.flush_o = 1'b1;
        if (cnt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Flush-length counter, loaded on the commit cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == S_COMMIT) begin
      cnt <= CNT_INIT;
    end else if (state == S_FLUSH && cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Record is captured only at detection and held until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      code_q <= '0;
      pc_q   <= '0;
      ds_q   <= 1'b0;
      bad_q  <= '0;
    end else if (hit) begin
      code_q <= det_code;
      pc_q   <= bus.mem_pc;
      ds_q   <= bus.mem_in_delayslot;
      bad_q  <= det_bad;
    end
  end

  assign bus.current_inst_addr_o = pc_q;
  assign bus.is_in_delayslot_o   = ds_q;
  assign bus.bad_addr_o          = bad_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: a vector table of single exceptions plus
// hand-written drain and reset-abort sequences.
module tb_exc_ctrl;

  logic clk;
  logic rst;
  exc_ctrl_if bus ();

  exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [7:0] F_IFADEL = 8'h80;
  localparam logic [7:0] F_RI     = 8'h40;
  localparam logic [7:0] F_OV     = 8'h20;
  localparam logic [7:0] F_SYS    = 8'h10;
  localparam logic [7:0] F_BRK    = 8'h08;
  localparam logic [7:0] F_ADEL   = 8'h04;
  localparam logic [7:0] F_ADES   = 8'h02;
  localparam logic [7:0] F_ERET   = 8'h01;
  localparam logic [31:0] VEC     = 32'hBFC00380;

  typedef struct {
    string       name;
    logic [7:0]  flags;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] exp_code;
    logic [31:0] exp_bad;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[11];
  int   n_cmp;
  int   n_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [7:0] flags, input logic [31:0] pc,
                       input logic ds, input logic [31:0] bad, input logic [31:0] status,
                       input logic [31:0] cause, input logic [31:0] epc, input logic busy);
    bus.mem_valid        = valid;
    bus.mem_pc           = pc;
    bus.mem_in_delayslot = ds;
    bus.exc_if_adel      = flags[7];
    bus.exc_ri           = flags[6];
    bus.exc_ov           = flags[5];
    bus.exc_syscall      = flags[4];
    bus.exc_break        = flags[3];
    bus.exc_adel         = flags[2];
    bus.exc_ades         = flags[1];
    bus.exc_eret         = flags[0];
    bus.mem_bad_addr     = bad;
    bus.status_i         = status;
    bus.cause_i          = cause;
    bus.epc_i            = epc;
    bus.bus_busy         = busy;
  endtask

  // One exception with an idle bus: detect, COMMIT, FLUSH, back to IDLE.
  task automatic apply_vec(input vec_t v);
    @(posedge clk); #1;
    drive(1'b1, v.flags, v.pc, v.ds, v.bad, v.status, v.cause, v.epc, 1'b0);
    @(negedge clk);
    chk({v.name, " detect stall"}, 32'(bus.stall_req_o), 32'd1);
    chk({v.name, " detect excepttype"}, bus.excepttype_o, 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 32'hDEAD0000, 1'b0, 32'hDEAD0001, 32'd0, 32'd0, v.epc, 1'b0);
    @(negedge clk);
    chk({v.name, " excepttype"}, bus.excepttype_o, v.exp_code);
    chk({v.name, " inst_addr"}, bus.current_inst_addr_o, v.pc);
    chk({v.name, " delayslot"}, 32'(bus.is_in_delayslot_o), 32'(v.ds));
    chk({v.name, " bad_addr"}, bus.bad_addr_o, v.exp_bad);
    chk({v.name, " new_pc"}, bus.new_pc_o, v.exp_pc);
    chk({v.name, " new_pc_valid"}, 32'(bus.new_pc_valid_o), 32'd1);
    chk({v.name, " commit flush"}, 32'(bus.flush_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk({v.name, " flush2"}, 32'(bus.flush_o), 32'd1);
    chk({v.name, " flush2 valid"}, 32'(bus.new_pc_valid_o), 32'd0);
    chk({v.name, " flush2 excepttype"}, bus.excepttype_o, 32'd0);
    chk({v.name, " hold inst_addr"}, bus.current_inst_addr_o, v.pc);
    @(posedge clk); #1;
    @(negedge clk);
    chk({v.name, " idle flush"}, 32'(bus.flush_o), 32'd0);
    chk({v.name, " idle stall"}, 32'(bus.stall_req_o), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    //         name           flags             pc            ds    bad           status        cause         epc           code   bad           new_pc
    vecs[0]  = '{"syscall",    F_SYS,            32'hBFC00100, 1'b0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h08, 32'h0,        VEC};
    vecs[1]  = '{"ades_ds",    F_ADES,           32'h80000010, 1'b1, 32'h00000003, 32'h0,        32'h0,        32'h0,        32'h05, 32'h00000003, VEC};
    vecs[2]  = '{"int_ov",     F_OV,             32'h80000020, 1'b0, 32'h0,        32'h00000401, 32'h00000400, 32'h0,        32'h01, 32'h0,        VEC};
    vecs[3]  = '{"exl_ov",     F_OV,             32'h80000024, 1'b0, 32'h0,        32'h00000403, 32'h00000400, 32'h0,        32'h0c, 32'h0,        VEC};
    vecs[4]  = '{"eret",       F_ERET,           32'h80000030, 1'b0, 32'h0,        32'h0,        32'h0,        32'h80001234, 32'h0e, 32'h0,        32'h80001234};
    vecs[5]  = '{"ifadel_ri",  F_IFADEL | F_RI,  32'h80000003, 1'b0, 32'h00005555, 32'h0,        32'h0,        32'h0,        32'h04, 32'h80000003, VEC};
    vecs[6]  = '{"ri_ov",      F_RI | F_OV,      32'h80000040, 1'b1, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0a, 32'h0,        VEC};
    vecs[7]  = '{"brk_adel",   F_BRK | F_ADEL,   32'h80000044, 1'b0, 32'h00001001, 32'h0,        32'h0,        32'h0,        32'h09, 32'h0,        VEC};
    vecs[8]  = '{"adel_multi", F_ADEL | F_ADES | F_ERET, 32'h80000048, 1'b0, 32'h00002002, 32'h0, 32'h0,       32'h80009999, 32'h04, 32'h00002002, VEC};
    vecs[9]  = '{"ie_off_sys", F_SYS,            32'h8000004c, 1'b0, 32'h0,        32'h00000400, 32'h00000400, 32'h0,        32'h08, 32'h0,        VEC};
    vecs[10] = '{"im_miss",    F_BRK,            32'h80000050, 1'b0, 32'h0,        32'h00000801, 32'h00000400, 32'h0,        32'h09, 32'h0,        VEC};

    // Reset with a live exception on the inputs: everything stays at zero.
    rst = 1'b0;
    drive(1'b1, F_SYS, 32'h12345678, 1'b1, 32'h9, 32'h0, 32'h0, 32'h0, 1'b0);
    #12;
    chk("reset stall", 32'(bus.stall_req_o), 32'd0);
    chk("reset flush", 32'(bus.flush_o), 32'd0);
    chk("reset excepttype", bus.excepttype_o, 32'd0);
    chk("reset new_pc_valid", 32'(bus.new_pc_valid_o), 32'd0);
    chk("reset inst_addr", bus.current_inst_addr_o, 32'd0);
    chk("reset bad_addr", bus.bad_addr_o, 32'd0);
    chk("reset delayslot", 32'(bus.is_in_delayslot_o), 32'd0);
    drive(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // No detection without mem_valid, or with mem_valid and no flags.
    @(posedge clk); #1;
    drive(1'b0, F_SYS, 32'h80000100, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("invalid stall", 32'(bus.stall_req_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b1, 8'h00, 32'h80000104, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("noflag stall", 32'(bus.stall_req_o), 32'd0);
    chk("invalid no commit", 32'(bus.new_pc_valid_o), 32'd0);
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("noflag no commit", 32'(bus.new_pc_valid_o), 32'd0);

    for (int i = 0; i < 11; i++) begin
      apply_vec(vecs[i]);
    end

    // Drain: bus busy three cycles, PC changes meanwhile; commit carries the original PC.
    @(posedge clk); #1;
    drive(1'b1, F_SYS, 32'hBFC00200, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(negedge clk);
    chk("drain detect stall", 32'(bus.stall_req_o), 32'd1);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      drive(1'b1, F_BRK, 32'hBFC00204 + 32'(c), 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
      @(negedge clk);
      chk("drain stall", 32'(bus.stall_req_o), 32'd1);
      chk("drain no commit", bus.excepttype_o, 32'd0);
      chk("drain no flush", 32'(bus.flush_o), 32'd0);
    end
    @(posedge clk); #1;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    chk("drain last stall", 32'(bus.stall_req_o), 32'd1);
    chk("drain last no commit", 32'(bus.new_pc_valid_o), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain commit excepttype", bus.excepttype_o, 32'h08);
    chk("drain commit inst_addr", bus.current_inst_addr_o, 32'hBFC00200);
    chk("drain commit delayslot", 32'(bus.is_in_delayslot_o), 32'd0);
    chk("drain commit new_pc", bus.new_pc_o, VEC);
    chk("drain commit valid", 32'(bus.new_pc_valid_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain flush2", 32'(bus.flush_o), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("drain idle flush", 32'(bus.flush_o), 32'd0);

    // Reset in DRAIN aborts immediately; nothing commits after release.
    @(posedge clk); #1;
    drive(1'b1, F_SYS, 32'h11110000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    @(posedge clk); #2;
    drive(1'b0, 8'h00, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
    chk("abort pre stall", 32'(bus.stall_req_o), 32'd1);
    chk("abort pre inst_addr", bus.current_inst_addr_o, 32'h11110000);
    rst = 1'b0;
    #1;
    chk("abort stall", 32'(bus.stall_req_o), 32'd0);
    chk("abort inst_addr", bus.current_inst_addr_o, 32'd0);
    chk("abort delayslot", 32'(bus.is_in_delayslot_o), 32'd0);
    bus.bus_busy = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("post-abort no commit", 32'(bus.new_pc_valid_o), 32'd0);
      chk("post-abort no flush", 32'(bus.flush_o), 32'd0);
    end
    apply_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
